instruction_queue: RTL

In-order instruction fetch queue that sits directly upstream of the dispatch unit in the Tomasulo core.
- Streams a program of PROG_LEN words from a synchronous instruction memory into a circular FIFO.
- Presents the head instruction, with its fields pre-split, to dispatch.
- Dispatch consumes the head with a Pop strobe.
- Top-level tomasulo instantiates it on the shared Clock/Reset.

---
 rtl/tomasulo_pkg.sv | 28 ++
 rtl/iq_storage.sv | 31 +++
 rtl/instruction_queue.sv | 110 +++++++++++
 3 files changed

// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo core: instruction word layout,
// opcode constants and the clog2 helper used to size pointers and counters.
package tomasulo_pkg;

  localparam int INSTR_W = 16;

  // Field bit positions inside an instruction word.
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int RD_MSB     = 11;
  localparam int RD_LSB     = 8;
  localparam int RS_MSB     = 7;
  localparam int RS_LSB     = 4;
  localparam int RT_MSB     = 3;
  localparam int RT_LSB     = 0;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;

  // Smallest n with 2**n >= value; evaluated at elaboration time.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/iq_storage.sv
// Entry array for the instruction queue: one synchronous write port and
// one combinational read port, so the head word is visible the cycle it lands.
module iq_storage
  import tomasulo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = INSTR_W,
  parameter int PTR_W = clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the incoming fetch word into the slot the tail pointer names.
  // NOTE: the array has no reset; an entry is only ever read after it has
  // been written, because Valid is driven by the occupancy count, which is reset.
  always_ff @(posedge Clock) begin
    // NOTE: non-blocking assignment for every registered value, so all
    // flops update together from pre-edge values.
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_queue.sv
// In-order instruction fetch queue feeding dispatch. Streams PROG_LEN words
// from a synchronous instruction memory into a circular FIFO, reserving a slot
// for every outstanding read so a returning word always has somewhere to land.
module instruction_queue #(
  parameter int INSTR_W  = tomasulo_pkg::INSTR_W,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 8,
  parameter int PROG_LEN = 7
) (
  input  logic                                 Clock,
  input  logic                                 Reset,
  input  logic                                 Pop,
  output logic                                 MemRdEn,
  output logic [ADDR_W-1:0]                    MemAddr,
  input  logic [INSTR_W-1:0]                   MemRdata,
  output logic [INSTR_W-1:0]                   Instr,
  output logic [3:0]                           Opcode,
  output logic [3:0]                           Rd,
  output logic [3:0]                           Rs,
  output logic [3:0]                           Rt,
  output logic                                 Valid,
  output logic                                 Full,
  output logic [tomasulo_pkg::clog2(DEPTH):0]  Count,
  output logic                                 Done
);

  import tomasulo_pkg::*;

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // One extra bit so PC can sit at PROG_LEN == 2**ADDR_W once fetch is over.
  localparam int PC_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [PC_W-1:0]  PROG_LEN_C = PC_W'(PROG_LEN);

  logic [PC_W-1:0]    pc;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic               inflight;
  logic               done_q;

  logic [CNT_W-1:0]   occupancy;
  logic               pop_ok;
  logic               drained;
  logic [INSTR_W-1:0] head_word;

  // Occupied plus reserved slots; the fetch rule keeps this at most DEPTH.
  assign occupancy = count + CNT_W'(inflight);

  assign MemRdEn = !Reset && (pc < PROG_LEN_C) && (occupancy < DEPTH_C);
  assign MemAddr = pc[ADDR_W-1:0];

  assign Valid   = (count != '0);
  assign Full    = (count == DEPTH_C);
  assign Count   = count;
  assign pop_ok  = Pop && Valid;
  assign drained = (pc == PROG_LEN_C) && !inflight && (count == '0);
  assign Done    = done_q;

  // A returning word is dropped if Reset is sampled on the same edge.
  iq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W),
    .PTR_W (PTR_W)
  ) u_storage (
    .Clock (Clock),
    .we    (inflight && !Reset),
    .waddr (tail),
    .wdata (MemRdata),
    .raddr (head),
    .rdata (head_word)
  );

  assign Instr  = Valid ? head_word : '0;
  assign Opcode = Instr[OPCODE_MSB:OPCODE_LSB];
  assign Rd     = Instr[RD_MSB:RD_LSB];
  assign Rs     = Instr[RS_MSB:RS_LSB];
  assign Rt     = Instr[RT_MSB:RT_LSB];

  // Fetch issue, fill, pop and occupancy tracking; Reset overrides all of it.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc       <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (MemRdEn) pc <= pc + 1'b1;
      inflight <= MemRdEn;

      if (inflight) tail <= tail + 1'b1;
      if (pop_ok)   head <= head + 1'b1;

      // Fill and pop together leave the count where it is.
      case ({inflight, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Done latches once everything has been fetched and dispatched.
      if (drained) done_q <= 1'b1;
    end
  end

endmodule
